// File: rtl/mac_pkg.sv
// Shared constants for the MAC arithmetic stage: state encoding, default widths,
// product-count ceiling.
package mac_pkg;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACCUM = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam int MAC_WIDTH     = 4;
  localparam int MAC_ACC_WIDTH = 10;

  localparam logic [1:0] COUNT_MAX = 2'd3;
endpackage

// File: rtl/mac_multiplier.sv
// Combinational unsigned WIDTH x WIDTH array multiplier: AND-gate partial
// products summed row by row through ripple-carry full adders.
module mac_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  logic [WIDTH:0] row;
  logic [WIDTH:0] nxt;
  logic           x;
  logic           y;
  logic           c;

  always_comb begin
    p   = '0;
    nxt = '0;
    x   = 1'b0;
    y   = 1'b0;
    c   = 1'b0;
    row = {1'b0, a & {WIDTH{b[0]}}};
    p[0] = row[0];
    // Each row adds the next partial product to the upper bits of the running sum.
    for (int i = 1; i < WIDTH; i++) begin
      c = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        x      = row[j+1];
        y      = a[j] & b[i];
        nxt[j] = x ^ y ^ c;
        c      = (x & y) | (x & c) | (y & c);
      end
      nxt[WIDTH] = c;
      row        = nxt;
      p[i]       = row[0];
    end
    p[2*WIDTH-1:WIDTH] = row[WIDTH:1];
  end
endmodule

// File: rtl/one_bit_register.sv
// Single flop with load enable and asynchronous active-high clear.
module one_bit_register (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/mac_accumulator.sv
// MAC arithmetic stage: multiply-accumulate while RUN_IN is high, then latch
// the result in DONE until the next reset.
//
//   state    | meaning
//   ST_IDLE  | cleared, waiting for the first enabled cycle
//   ST_ACCUM | adding one product per cycle while RUN_IN=1
//   ST_DONE  | result frozen, DONE_OUT=1, left only via reset
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH     = MAC_WIDTH,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET_IN,
  input  logic                 RUN_IN,
  input  logic [WIDTH-1:0]     A_IN,
  input  logic [WIDTH-1:0]     B_IN,
  output logic [ACC_WIDTH-1:0] ACC_OUT,
  output logic [1:0]           COUNT_OUT,
  output logic                 DONE_OUT,
  output logic                 OVF_OUT
);
  logic [2*WIDTH-1:0]   product;
  logic [ACC_WIDTH-1:0] product_ext;
  logic                 trunc_lost;
  logic [ACC_WIDTH:0]   sum;
  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [1:0]           count_d;
  logic                 accum_en;
  logic                 done_d;
  logic                 ovf_d;

  mac_multiplier #(.WIDTH(WIDTH)) u_mult (
    .a (A_IN),
    .b (B_IN),
    .p (product)
  );

  generate
    if (ACC_WIDTH >= 2*WIDTH) begin : g_ext
      assign product_ext = ACC_WIDTH'(product);
      assign trunc_lost  = 1'b0;
    end else begin : g_trunc
      assign product_ext = product[ACC_WIDTH-1:0];
      assign trunc_lost  = |product[2*WIDTH-1:ACC_WIDTH];
    end
  endgenerate

  assign sum = {1'b0, ACC_OUT} + {1'b0, product_ext};

  always_comb begin
    state_d  = state_q;
    count_d  = COUNT_OUT;
    accum_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RUN_IN) begin
          accum_en = 1'b1;
          count_d  = 2'd1;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (RUN_IN) begin
          accum_en = 1'b1;
          if (COUNT_OUT != COUNT_MAX) begin
            count_d = COUNT_OUT + 2'd1;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // accum_en gates the operands out of the flags, so idle-cycle operand values never reach state.
  assign ovf_d  = OVF_OUT | (accum_en & (sum[ACC_WIDTH] | trunc_lost));
  assign done_d = (state_d == ST_DONE);

  generate
    for (genvar k = 0; k < ACC_WIDTH; k++) begin : g_acc
      one_bit_register u_acc (
        .clk (CLK), .rst (RESET_IN), .en (accum_en), .d (sum[k]), .q (ACC_OUT[k])
      );
    end
    for (genvar k = 0; k < 2; k++) begin : g_ctl
      one_bit_register u_state (
        .clk (CLK), .rst (RESET_IN), .en (1'b1), .d (state_d[k]), .q (state_q[k])
      );
      one_bit_register u_count (
        .clk (CLK), .rst (RESET_IN), .en (1'b1), .d (count_d[k]), .q (COUNT_OUT[k])
      );
    end
  endgenerate

  one_bit_register u_done (
    .clk (CLK), .rst (RESET_IN), .en (1'b1), .d (done_d), .q (DONE_OUT)
  );

  one_bit_register u_ovf (
    .clk (CLK), .rst (RESET_IN), .en (1'b1), .d (ovf_d), .q (OVF_OUT)
  );
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: default-width and 8-bit-accumulator
// instances driven together, checked against an arithmetic reference model.
module tb_mac_accumulator;
  logic       CLK = 1'b0;
  logic       RESET_IN;
  logic       RUN_IN;
  logic [3:0] A_IN;
  logic [3:0] B_IN;
  logic [9:0] acc10;
  logic [1:0] cnt10;
  logic       done10;
  logic       ovf10;
  logic [7:0] acc8;
  logic [1:0] cnt8;
  logic       done8;
  logic       ovf8;

  typedef struct {
    int acc;
    int cnt;
    int done;
    int ovf;
  } exp_t;

  exp_t q10[$];
  exp_t q8[$];

  int m_acc[2];
  int m_cnt[2];
  int m_phase[2];   // 0 idle, 1 running, 2 finished
  int m_ovf[2];

  int n_checks = 0;
  int n_fail   = 0;

  mac_accumulator dut (
    .CLK (CLK), .RESET_IN (RESET_IN), .RUN_IN (RUN_IN), .A_IN (A_IN), .B_IN (B_IN),
    .ACC_OUT (acc10), .COUNT_OUT (cnt10), .DONE_OUT (done10), .OVF_OUT (ovf10)
  );

  mac_accumulator #(.WIDTH(4), .ACC_WIDTH(8)) dut8 (
    .CLK (CLK), .RESET_IN (RESET_IN), .RUN_IN (RUN_IN), .A_IN (A_IN), .B_IN (B_IN),
    .ACC_OUT (acc8), .COUNT_OUT (cnt8), .DONE_OUT (done8), .OVF_OUT (ovf8)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit run, input int a, input int b);
    int lim;
    int s;
    lim = (k == 0) ? 1024 : 256;
    if (rst) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_phase[k] = 0;
    end else if (m_phase[k] == 2) begin
      // finished: everything frozen
    end else if (run) begin
      s = m_acc[k] + a * b;
      if (s >= lim) m_ovf[k] = 1;
      m_acc[k]   = s % lim;
      m_cnt[k]   = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
      m_phase[k] = 1;
    end else if (m_phase[k] == 1) begin
      m_phase[k] = 2;
    end
  endtask

  function automatic exp_t snapshot(input int k);
    exp_t e;
    e.acc  = m_acc[k];
    e.cnt  = m_cnt[k];
    e.done = (m_phase[k] == 2) ? 1 : 0;
    e.ovf  = m_ovf[k];
    return e;
  endfunction

  task automatic cycle(input bit rst, input bit run, input int a, input int b);
    @(negedge CLK);
    RESET_IN = rst;
    RUN_IN   = run;
    A_IN     = a[3:0];
    B_IN     = b[3:0];
    @(posedge CLK);
    for (int k = 0; k < 2; k++) model_step(k, rst, run, a, b);
    q10.push_back(snapshot(0));
    q8.push_back(snapshot(1));
  endtask

  task automatic run_n(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, a, b);
  endtask

  // Monitor: outputs are registered, so every edge presents a new result.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q10.size() > 0) begin
        e = q10.pop_front();
        check("acc10",  int'(acc10),  e.acc);
        check("cnt10",  int'(cnt10),  e.cnt);
        check("done10", int'(done10), e.done);
        check("ovf10",  int'(ovf10),  e.ovf);
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("acc8",  int'(acc8),  e.acc);
        check("cnt8",  int'(cnt8),  e.cnt);
        check("done8", int'(done8), e.done);
        check("ovf8",  int'(ovf8),  e.ovf);
      end
    end
  end

  initial begin
    int budget;
    RESET_IN = 1'b1;
    RUN_IN   = 1'b0;
    A_IN     = 4'd0;
    B_IN     = 4'd0;
    #1;
    check("reset_acc",  int'(acc10),  0);
    check("reset_cnt",  int'(cnt10),  0);
    check("reset_done", int'(done10), 0);
    check("reset_ovf",  int'(ovf10),  0);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);

    // 3 x (3*4), then stop; then try to restart from DONE
    run_n(3, 3, 4);
    cycle(1'b0, 1'b0, 7, 9);
    #2;
    check("t1_acc",  int'(acc10),  36);
    check("t1_cnt",  int'(cnt10),  3);
    check("t1_done", int'(done10), 1);
    check("t1_ovf",  int'(ovf10),  0);
    run_n(2, 5, 5);
    #2;
    check("frozen_acc",  int'(acc10),  36);
    check("frozen_cnt",  int'(cnt10),  3);
    check("frozen_done", int'(done10), 1);

    // full-scale products
    cycle(1'b1, 1'b0, 0, 0);
    run_n(3, 15, 15);
    cycle(1'b0, 1'b0, 0, 0);
    #2;
    check("fs_acc10", int'(acc10), 675);
    check("fs_ovf10", int'(ovf10), 0);

    // 8-bit accumulator wraps on the second full-scale product
    cycle(1'b1, 1'b0, 0, 0);
    run_n(2, 15, 15);
    #2;
    check("wrap_acc8", int'(acc8), 194);
    check("wrap_ovf8", int'(ovf8), 1);
    cycle(1'b0, 1'b0, 0, 0);
    #2;
    check("wrap_ovf8_sticky", int'(ovf8), 1);

    // asynchronous abort between edges
    cycle(1'b1, 1'b0, 0, 0);
    run_n(2, 3, 4);
    #3;
    RESET_IN = 1'b1;
    #1;
    check("abort_acc",  int'(acc10),  0);
    check("abort_cnt",  int'(cnt10),  0);
    check("abort_done", int'(done10), 0);
    check("abort_ovf",  int'(ovf10),  0);
    for (int k = 0; k < 2; k++) model_step(k, 1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 2, 2);
    #2;
    check("rerun_acc", int'(acc10), 4);
    check("rerun_cnt", int'(cnt10), 1);

    // run longer than the upstream cap
    cycle(1'b1, 1'b0, 0, 0);
    run_n(5, 1, 1);
    #2;
    check("long_acc", int'(acc10), 5);
    check("long_cnt", int'(cnt10), 3);
    check("long_ovf", int'(ovf10), 0);

    // high/low/high: the second high must be ignored
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 6, 7);
    cycle(1'b0, 1'b0, 6, 7);
    cycle(1'b0, 1'b1, 6, 7);
    cycle(1'b0, 1'b1, 6, 7);

    // random runs; operands stay random while RUN_IN=0 too
    for (int it = 0; it < 40; it++) begin
      cycle(1'b1, 1'b0, $urandom_range(15), $urandom_range(15));
      for (int c = 0; c < 10; c++) begin
        cycle(1'b0, ($urandom_range(3) != 0), $urandom_range(15), $urandom_range(15));
      end
    end

    budget = 0;
    while ((q10.size() > 0 || q8.size() > 0) && budget < 5) begin
      @(posedge CLK);
      budget++;
    end
    #2;
    check("scoreboard_drained", q10.size() + q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
